// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong game state, paddles, ball and scores.
// Define PONG_AI_P2_EN to make the right paddle track the ball by itself.
module pong_game_ctrl #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED_X = 4,
  parameter int BALL_SPEED_Y = 2,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] p1_paddle_pos,
  output logic [9:0] p2_paddle_pos,
  output logic [9:0] ball_x_pos,
  output logic [9:0] ball_y_pos,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over
);

  localparam int PADDLE_X = 25;
  localparam int PADDLE_Y = 25;
  localparam int PADDLE_W = 20;
  localparam int PADDLE_H = 125;
  localparam int BALL     = 16;
  localparam int PMAX     = HEIGHT - 2*PADDLE_Y - PADDLE_H;
  localparam int BMAX_Y   = HEIGHT - BALL;
  localparam int CX       = 312;
  localparam int CY       = 232;
  localparam int P_RST    = 152;
  localparam int L_HIT    = PADDLE_X + PADDLE_W + 1;
  localparam int R_HIT    = WIDTH - PADDLE_X - PADDLE_W - BALL;
  localparam int CW       =
    (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    PLAY,
    GAME_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    p1_q, p1_d;
  logic [9:0]    p2_q, p2_d;
  logic [9:0]    bx_q, bx_d;
  logic [9:0]    by_q, by_d;
  logic          dx_q, dx_d;
  logic          dy_q, dy_d;
  logic          sdir_q, sdir_d;
  logic          go_q, go_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic p2_u, p2_dn;

`ifdef PONG_AI_P2_EN
  int   p2_mid, b_mid;
  logic unused_p2;
  assign unused_p2 = p2_up ^ p2_down;
  assign p2_mid    = PADDLE_Y + int'(p2_q) + 62;
  assign b_mid     = int'(by_q) + 8;
  assign p2_u      = p2_mid > b_mid;
  assign p2_dn     = p2_mid < b_mid;
`else
  assign p2_u  = p2_up;
  assign p2_dn = p2_down;
`endif

  // int arithmetic keeps saturation free of 10-bit wrap
  function automatic logic [9:0] pad_step(
    input logic [9:0] pos,
    input logic       up,
    input logic       dn
  );
    int p;
    p = int'(pos);
    if (up && !dn)
      p = (p - PADDLE_SPEED < 0) ? 0 : p - PADDLE_SPEED;
    else if (dn && !up)
      p = (p + PADDLE_SPEED > PMAX) ? PMAX : p + PADDLE_SPEED;
    return 10'(p);
  endfunction

  int   bx_i, by_i, nx, ny;
  logic hit1, hit2, ndx, ndy;
  logic miss_l, miss_r;

  always_comb begin
    bx_i   = int'(bx_q);
    by_i   = int'(by_q);
    hit1   = (by_i + BALL - 1 >= PADDLE_Y + int'(p1_q)) &&
             (by_i <= PADDLE_Y + int'(p1_q) + PADDLE_H);
    hit2   = (by_i + BALL - 1 >= PADDLE_Y + int'(p2_q)) &&
             (by_i <= PADDLE_Y + int'(p2_q) + PADDLE_H);
    ny     = by_i;
    ndy    = dy_q;
    nx     = bx_i;
    ndx    = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (dy_q) begin
      if (by_i + BALL_SPEED_Y >= BMAX_Y) begin
        ny  = BMAX_Y;
        ndy = 1'b0;
      end else begin
        ny = by_i + BALL_SPEED_Y;
      end
    end else if (by_i <= BALL_SPEED_Y) begin
      ny  = 0;
      ndy = 1'b1;
    end else begin
      ny = by_i - BALL_SPEED_Y;
    end
    if (dx_q) begin
      if (bx_i + BALL_SPEED_X >= R_HIT && hit2) begin
        nx  = R_HIT;
        ndx = 1'b0;
      end else if (bx_i + BALL_SPEED_X > WIDTH - BALL) begin
        miss_r = 1'b1;
      end else begin
        nx = bx_i + BALL_SPEED_X;
      end
    end else begin
      if (bx_i - BALL_SPEED_X <= L_HIT && hit1) begin
        nx  = L_HIT;
        ndx = 1'b1;
      end else if (bx_i < BALL_SPEED_X) begin
        miss_l = 1'b1;
      end else begin
        nx = bx_i - BALL_SPEED_X;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sdir_d  = sdir_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SERVE;
            sdir_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        SERVE: begin
          p1_d = pad_step(p1_q, p1_up, p1_down);
          p2_d = pad_step(p2_q, p2_u, p2_dn);
          bx_d = 10'(CX);
          by_d = 10'(CY);
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            dx_d    = sdir_q;
            dy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PLAY: begin
          p1_d = pad_step(p1_q, p1_up, p1_down);
          p2_d = pad_step(p2_q, p2_u, p2_dn);
          bx_d = 10'(nx);
          by_d = 10'(ny);
          dx_d = ndx;
          dy_d = ndy;
          // a miss re-centres the ball and serves toward the loser
          if (miss_r || miss_l) begin
            bx_d  = 10'(CX);
            by_d  = 10'(CY);
            cnt_d = '0;
            if (miss_r) begin
              s1_d   = s1_q + 4'd1;
              sdir_d = 1'b1;
            end else begin
              s2_d   = s2_q + 4'd1;
              sdir_d = 1'b0;
            end
            if ((miss_r && s1_d == 4'(WIN_SCORE)) ||
                (miss_l && s2_d == 4'(WIN_SCORE)))
              state_d = GAME_OVER;
            else
              state_d = SERVE;
          end
        end
        GAME_OVER: begin
          bx_d = 10'(CX);
          by_d = 10'(CY);
          if (start) begin
            state_d = SERVE;
            s1_d    = '0;
            s2_d    = '0;
            sdir_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    go_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p1_q    <= 10'(P_RST);
      p2_q    <= 10'(P_RST);
      bx_q    <= 10'(CX);
      by_q    <= 10'(CY);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sdir_q  <= 1'b1;
      go_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sdir_q  <= sdir_d;
      go_q    <= go_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p1_paddle_pos = p1_q;
  assign p2_paddle_pos = p2_q;
  assign ball_x_pos    = bx_q;
  assign ball_y_pos    = by_q;
  assign p1_score      = s1_q;
  assign p2_score      = s2_q;
  assign game_over     = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed rallies with hand-derived ball trajectories.
// Default build (right paddle driven by its buttons).
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [9:0] p1_paddle_pos, p2_paddle_pos;
  logic [9:0] ball_x_pos, ball_y_pos;
  logic [3:0] p1_score, p2_score;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  pong_game_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .p1_up         (p1_up),
    .p1_down       (p1_down),
    .p2_up         (p2_up),
    .p2_down       (p2_down),
    .p1_paddle_pos (p1_paddle_pos),
    .p2_paddle_pos (p2_paddle_pos),
    .ball_x_pos    (ball_x_pos),
    .ball_y_pos    (ball_y_pos),
    .p1_score      (p1_score),
    .p2_score      (p2_score),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input int p1, input int p2,
                         input int x, input int y,
                         input int s1, input int s2,
                         input int go);
    chk({tag, ".p1"}, 32'(p1_paddle_pos), p1);
    chk({tag, ".p2"}, 32'(p2_paddle_pos), p2);
    chk({tag, ".x"}, 32'(ball_x_pos), x);
    chk({tag, ".y"}, 32'(ball_y_pos), y);
    chk({tag, ".s1"}, 32'(p1_score), s1);
    chk({tag, ".s2"}, 32'(p2_score), s2);
    chk({tag, ".go"}, 32'(game_over), go);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    p1_up = 1'b0;
    p1_down = 1'b0;
    p2_up = 1'b0;
    p2_down = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 152, 152, 312, 232, 0, 0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("no_tick", 152, 152, 312, 232, 0, 0, 0);
    ticks(10);
    chk_all("idle10", 152, 152, 312, 232, 0, 0, 0);

    p1_up = 1'b1;
    p2_down = 1'b1;
    tick();
    p1_up = 1'b0;
    p2_down = 1'b0;
    chk("idle_btn.p1", 32'(p1_paddle_pos), 152);
    chk("idle_btn.p2", 32'(p2_paddle_pos), 152);

    // rally A: p2 returns, p1 returns, p2 misses
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("serve0", 152, 152, 312, 232, 0, 0, 0);
    p1_up = 1'b1;
    p1_down = 1'b1;
    p2_down = 1'b1;
    tick();
    chk("serve1.p1", 32'(p1_paddle_pos), 152);
    chk("serve1.p2", 32'(p2_paddle_pos), 156);
    ticks(19);
    p1_up = 1'b0;
    p1_down = 1'b0;
    p2_down = 1'b0;
    chk("both_hold.p1", 32'(p1_paddle_pos), 152);
    chk("p2_down20", 32'(p2_paddle_pos), 232);
    ticks(39);
    chk("serve59.x", 32'(ball_x_pos), 312);
    tick();
    chk("serve60.x", 32'(ball_x_pos), 312);
    chk("serve60.y", 32'(ball_y_pos), 232);
    tick();
    chk("play1.x", 32'(ball_x_pos), 316);
    chk("play1.y", 32'(ball_y_pos), 234);
    ticks(65);
    chk("t66.x", 32'(ball_x_pos), 576);
    chk("t66.y", 32'(ball_y_pos), 364);
    tick();
    chk("p2_bounce.x", 32'(ball_x_pos), 579);
    chk("p2_bounce.y", 32'(ball_y_pos), 366);
    tick();
    chk("p2_bounce_dir.x", 32'(ball_x_pos), 575);
    ticks(132);
    chk("t200.x", 32'(ball_x_pos), 47);
    chk("t200.y", 32'(ball_y_pos), 296);
    tick();
    chk("p1_bounce.x", 32'(ball_x_pos), 46);
    chk("p1_bounce.y", 32'(ball_y_pos), 294);
    tick();
    chk("p1_bounce_dir.x", 32'(ball_x_pos), 50);
    chk("p1_bounce_dir.y", 32'(ball_y_pos), 292);
    ticks(143);
    chk("t345.x", 32'(ball_x_pos), 622);
    chk("t345.y", 32'(ball_y_pos), 6);
    chk("t345.s1", 32'(p1_score), 0);
    tick();
    chk_all("p1_point", 152, 232, 312, 232, 1, 0, 0);

    // rally B: p1 paddle parked at the top, p1 misses
    p1_up = 1'b1;
    ticks(37);
    chk("up37", 32'(p1_paddle_pos), 4);
    tick();
    chk("up38", 32'(p1_paddle_pos), 0);
    ticks(12);
    chk("up50", 32'(p1_paddle_pos), 0);
    p1_up = 1'b0;
    ticks(10);
    chk("b_serve_end.x", 32'(ball_x_pos), 312);
    ticks(200);
    chk("b_t200.x", 32'(ball_x_pos), 47);
    chk("b_t200.y", 32'(ball_y_pos), 296);
    tick();
    chk("p1_miss.x", 32'(ball_x_pos), 43);
    ticks(10);
    chk("b_t211.x", 32'(ball_x_pos), 3);
    tick();
    chk_all("p2_point", 0, 232, 312, 232, 1, 1, 0);

    // rally C: serve toward p1, p1 returns, p2 parked out of reach
    p1_down = 1'b1;
    p2_up = 1'b1;
    tick();
    chk("c_serve1.p1", 32'(p1_paddle_pos), 4);
    chk("c_serve1.p2", 32'(p2_paddle_pos), 228);
    ticks(59);
    p1_down = 1'b0;
    p2_up = 1'b0;
    chk("c_serve_end.p1", 32'(p1_paddle_pos), 240);
    chk("c_serve_end.p2", 32'(p2_paddle_pos), 0);
    tick();
    chk("serve_left.x", 32'(ball_x_pos), 308);
    chk("serve_left.y", 32'(ball_y_pos), 234);
    ticks(65);
    chk("c_t66.x", 32'(ball_x_pos), 48);
    tick();
    chk("c_p1_bounce.x", 32'(ball_x_pos), 46);
    chk("c_p1_bounce.y", 32'(ball_y_pos), 366);
    ticks(144);
    chk("c_t211.x", 32'(ball_x_pos), 622);
    tick();
    chk_all("c_point", 240, 0, 312, 232, 2, 1, 0);

    // rallies D..H: p2 never reaches the ball
    for (int r = 0; r < 5; r++) begin
      ticks(138);
      chk("edge624.x", 32'(ball_x_pos), 624);
      tick();
      chk("run.s1", 32'(p1_score), 32'(3 + r));
      chk("run.go", 32'(game_over), (r == 4) ? 1 : 0);
    end
    chk_all("over", 240, 0, 312, 232, 7, 1, 1);
    p1_up = 1'b1;
    p2_down = 1'b1;
    ticks(3);
    p1_up = 1'b0;
    p2_down = 1'b0;
    chk_all("over_hold", 240, 0, 312, 232, 7, 1, 1);

    start = 1'b1;
    tick();
    chk_all("restart", 240, 0, 312, 232, 0, 0, 0);
    ticks(59);
    chk("restart59.x", 32'(ball_x_pos), 312);
    tick();
    tick();
    chk("restart_play1.x", 32'(ball_x_pos), 316);
    chk("restart_play1.y", 32'(ball_y_pos), 234);
    ticks(5);
    start = 1'b0;
    chk("pre_rst.x", 32'(ball_x_pos), 336);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 152, 152, 312, 232, 0, 0, 0);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk_all("rst_dominates", 152, 152, 312, 232, 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_all("post_rst", 152, 152, 312, 232, 0, 0, 0);
    tick();
    chk_all("post_rst_tick", 152, 152, 312, 232, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
